alu_engine: RTL
===============

Name: alu_engine

Overview:
- Multi-cycle arithmetic responder on the CPU core's ALU request/done handshake; the control unit is the initiator.
- Accepts an operation code and two operands on a single-cycle request.
- Computes ADD/SUB in one cycle, and MUL/DIV iteratively (shift-add multiply, restoring divide).
- Returns the result with a single-cycle done pulse, then holds it for the control unit to write to memory.

Parameters:
REG_SIZE, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
alu_operation  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
alu_op1  input  REG_SIZE  first operand (minuend / multiplicand / dividend)
alu_op2  input  REG_SIZE  second operand (subtrahend / multiplier / divisor)
alu_req  input  1  start request, sampled only in IDLE
alu_done  output  1  one-cycle pulse: alu_res valid
alu_res  output  REG_SIZE  result (sum, difference, low product bits, quotient)
alu_rem  output  REG_SIZE  DIV remainder; 0 for other operations
alu_busy  output  1  high while an operation is in flight (CALC or DONE)
alu_div_zero  output  1  set with alu_done when DIV had alu_op2 == 0

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - alu_done, alu_busy, alu_div_zero = 0; alu_res, alu_rem = 0.
  - Iteration counter and shift registers cleared.
  - Reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - On alu_req = 1 at a rising edge: latch operation, op1, op2.
  - ADD/SUB go to DONE; MUL/DIV go to CALC with counter = REG_SIZE.
  - alu_req = 0 keeps IDLE.
- CALC: one iteration per cycle, counter decrements; after the REG_SIZE-th iteration go to DONE.
  - MUL: if multiplier LSB = 1, add multiplicand to accumulator; then shift multiplicand left and multiplier right. Only the low REG_SIZE bits are kept.
  - DIV (unsigned restoring): shift {rem, dividend} left by 1; if rem >= divisor, subtract and set quotient bit to 1.
- DONE:
  - alu_done = 1 for exactly this cycle; alu_res/alu_rem/alu_div_zero show the final values.
  - Next state is IDLE, unconditionally.
- Latency (request sampled at edge N):
  - ADD/SUB: alu_done high in cycle N+1.
  - MUL/DIV: alu_done high in cycle N+REG_SIZE+1.
- alu_res, alu_rem and alu_div_zero hold their values after the pulse until the next DONE or reset. alu_div_zero is cleared on every new accept.
- alu_busy = 1 in CALC and DONE; 0 in IDLE.
- Arithmetic: all operands unsigned; results modulo 2^REG_SIZE (ADD overflow and SUB borrow wrap, no flags).
- Divide by zero: full latency still applies.
  - alu_res = all ones; alu_rem = op1; alu_div_zero = 1.
  - This falls out of restoring division; the flag is computed from the latched op2.
- alu_req outside IDLE (CALC or DONE) is ignored and not queued.
  - A request held high through DONE is accepted on the first IDLE edge, so back-to-back requests have a 1-cycle gap.
- Operand inputs are don't-care except on the accepting edge.

Test Plan:
- Reset: rst = 0 mid-run, release → alu_done = 0, alu_res = 0, alu_busy = 0; a following ADD 3+4 gives alu_res = 7 with done at N+1.
- ADD/SUB wrap (REG_SIZE = 8):
  - ADD 200+100 → alu_res = 44, done exactly at N+1.
  - SUB 5-7 → alu_res = 254, alu_rem = 0.
- MUL:
  - 13*11 → alu_res = 143, done at N+9, alu_busy high for cycles N+1..N+9.
  - 20*20 → alu_res = 144 (400 mod 256).
  - 0*255 → 0.
- DIV:
  - 200/7 → alu_res = 28, alu_rem = 4, alu_div_zero = 0.
  - 255/1 → 255, rem 0.
  - 200/0 → alu_res = 255, alu_rem = 200, alu_div_zero = 1, done at N+9.
- Handshake:
  - alu_req pulsed during CALC → ignored, single done pulse, result from the first operands.
  - alu_req held high continuously with ADD 1+1 → done pulses every 2 cycles.
- Reset mid-MUL: assert rst at cycle N+4 of 13*11 → no done pulse, alu_busy = 0, alu_res = 0; a subsequent MUL 3*3 gives 9 at N'+9.

Source files
------------

// File: rtl/alu_engine.sv
// Multi-cycle ALU responder: ADD/SUB direct, MUL shift-add, DIV restoring (unsigned).
// Latency: ADD/SUB done one cycle after accept; MUL/DIV done REG_SIZE+1 cycles after accept.
// Backpressure: requests seen while busy are dropped (never queued); results hold until the next done.
module alu_engine #(
  parameter int REG_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          alu_operation,
  input  logic [REG_SIZE-1:0] alu_op1,
  input  logic [REG_SIZE-1:0] alu_op2,
  input  logic                alu_req,
  output logic                alu_done,
  output logic [REG_SIZE-1:0] alu_res,
  output logic [REG_SIZE-1:0] alu_rem,
  output logic                alu_busy,
  output logic                alu_div_zero
);

  localparam int CW = $clog2(REG_SIZE + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  // MUL: multiplicand shifting left; DIV: dividend shifting out, quotient shifting in
  logic [REG_SIZE-1:0] a_q, a_d;
  // MUL: multiplier shifting right; DIV: divisor (constant)
  logic [REG_SIZE-1:0] b_q, b_d;
  // MUL: product accumulator; DIV: partial remainder
  logic [REG_SIZE-1:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [REG_SIZE-1:0] res_q, res_d;
  logic [REG_SIZE-1:0] rem_q, rem_d;
  logic                dz_q, dz_d;
  // Shifted remainder needs one extra bit: remainder < divisor can still overflow when doubled
  logic [REG_SIZE:0]   rs;

  // Next-state, datapath iteration and result capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    rs      = '0;

    case (state_q)
      S_IDLE: begin
        if (alu_req) begin
          op_d  = alu_operation;
          a_d   = alu_op1;
          b_d   = alu_op2;
          acc_d = '0;
          cnt_d = CW'(REG_SIZE);
          dz_d  = 1'b0;
          case (alu_operation)
            OP_ADD: begin
              res_d   = alu_op1 + alu_op2;
              rem_d   = '0;
              state_d = S_DONE;
            end
            OP_SUB: begin
              res_d   = alu_op1 - alu_op2;
              rem_d   = '0;
              state_d = S_DONE;
            end
            default: state_d = S_CALC;
          endcase
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end else begin
          rs = {acc_q, a_q[REG_SIZE-1]};
          if (rs >= {1'b0, b_q}) begin
            // Difference is below the divisor, so the low bits are exact
            acc_d = rs[REG_SIZE-1:0] - b_q;
            a_d   = {a_q[REG_SIZE-2:0], 1'b1};
          end else begin
            acc_d = rs[REG_SIZE-1:0];
            a_d   = {a_q[REG_SIZE-2:0], 1'b0};
          end
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (op_q == OP_MUL) begin
            res_d = acc_d;
            rem_d = '0;
          end else begin
            res_d = a_d;
            rem_d = acc_d;
            dz_d  = (b_q == '0);
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign alu_done     = (state_q == S_DONE);
  assign alu_busy     = (state_q != S_IDLE);
  assign alu_res      = res_q;
  assign alu_rem      = rem_q;
  assign alu_div_zero = dz_q;

endmodule
